// File: rtl/table_fsm_if.sv
// ============================================================================
//  Module      : table_fsm_if
//  Description : Step/preset and table configuration bundle for table_fsm.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface table_fsm_if #(
    parameter int STATE_W = 4,
    parameter int IN_W    = 4,
    parameter int OUT_W   = 4
);
    logic                       ENABLE;
    logic [IN_W-1:0]            X;
    logic [STATE_W-1:0]         PRESET_Y;
    logic [STATE_W-1:0]         Y;
    logic [OUT_W-1:0]           Z;
    logic                       CHANGED;
    logic                       CFG_WE;
    logic [STATE_W+IN_W-1:0]    CFG_ADDR;
    logic [STATE_W+OUT_W-1:0]   CFG_WDATA;
    logic [STATE_W+OUT_W-1:0]   CFG_RDATA;

    modport master (
        output ENABLE, X, PRESET_Y, CFG_WE, CFG_ADDR, CFG_WDATA,
        input  Y, Z, CHANGED, CFG_RDATA
    );

    modport slave (
        input  ENABLE, X, PRESET_Y, CFG_WE, CFG_ADDR, CFG_WDATA,
        output Y, Z, CHANGED, CFG_RDATA
    );
endinterface

`default_nettype wire

// File: rtl/table_fsm.sv
// ============================================================================
//  Module      : table_fsm
//  Description : Runtime-programmable table-driven FSM; entry {next_state, out}
//                indexed by {state, symbol}, one transition per enabled clock.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module table_fsm #(
    parameter int                 STATE_W     = 4,
    parameter int                 IN_W        = 4,
    parameter int                 OUT_W       = 4,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    table_fsm_if.slave      bus
);
    localparam int c_ADDR_W  = STATE_W + IN_W;
    localparam int c_ENTRY_W = STATE_W + OUT_W;
    localparam int c_DEPTH   = 1 << c_ADDR_W;

    logic [c_ENTRY_W-1:0] r_table [c_DEPTH];
    logic [STATE_W-1:0]   r_y;
    logic [OUT_W-1:0]     r_z;
    logic                 r_changed;
    logic [c_ENTRY_W-1:0] r_rdata;

    logic [c_ENTRY_W-1:0] w_entry;
    logic [STATE_W-1:0]   w_next;
    logic [OUT_W-1:0]     w_out;

    // Each entry resets to a self-loop on its own state with zero output.
    for (genvar i = 0; i < c_DEPTH; i++) begin : g_entry
        localparam logic [c_ADDR_W-1:0]  c_ADDR  = c_ADDR_W'(i);
        localparam logic [c_ENTRY_W-1:0] c_RESET = {c_ADDR[c_ADDR_W-1 -: STATE_W], {OUT_W{1'b0}}};

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_table[i] <= c_RESET;
            end else if (bus.CFG_WE && (bus.CFG_ADDR == c_ADDR)) begin
                r_table[i] <= bus.CFG_WDATA;
            end
        end
    end

    always_comb begin
        w_entry = r_table[{r_y, bus.X}];
        w_next  = w_entry[c_ENTRY_W-1 -: STATE_W];
        w_out   = w_entry[OUT_W-1:0];
    end

    // Lookup and readback see pre-write table contents on a same-edge write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_y       <= RESET_STATE;
            r_z       <= '0;
            r_changed <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rdata <= r_table[bus.CFG_ADDR];
            if (!bus.ENABLE) begin
                r_y       <= bus.PRESET_Y;
                r_z       <= '0;
                r_changed <= 1'b0;
            end else begin
                r_y       <= w_next;
                r_z       <= w_out;
                r_changed <= (w_next != r_y);
            end
        end
    end

    assign bus.Y         = r_y;
    assign bus.Z         = r_z;
    assign bus.CHANGED   = r_changed;
    assign bus.CFG_RDATA = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_table_fsm.sv
// ============================================================================
//  Module      : tb_table_fsm
//  Description : Self-checking bench for table_fsm against an array-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_table_fsm;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    table_fsm_if #(.STATE_W(4), .IN_W(4), .OUT_W(4)) bus ();

    table_fsm #(
        .STATE_W    (4),
        .IN_W       (4),
        .OUT_W      (4),
        .RESET_STATE(4'h0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int unsigned m_tbl [256];
    int unsigned m_y, m_z, m_ch, m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_tbl[a] = (a / 16) * 16;
        m_y = 0; m_z = 0; m_ch = 0; m_rd = 0;
    endtask

    task automatic drive(input bit en, input int unsigned x, input int unsigned py,
                         input bit we, input int unsigned addr, input int unsigned wd);
        bus.ENABLE    = en;
        bus.X         = 4'(x);
        bus.PRESET_Y  = 4'(py);
        bus.CFG_WE    = we;
        bus.CFG_ADDR  = 8'(addr);
        bus.CFG_WDATA = 8'(wd);
    endtask

    // One clock: predict from the pre-edge inputs, then compare just after the edge.
    task automatic cycle();
        int unsigned e, ny, nz, nc, nr;
        if (bus.ENABLE) begin
            e  = m_tbl[m_y * 16 + 32'(bus.X)];
            ny = e / 16;
            nz = e % 16;
            nc = (ny != m_y) ? 1 : 0;
        end else begin
            ny = 32'(bus.PRESET_Y);
            nz = 0;
            nc = 0;
        end
        nr = m_tbl[bus.CFG_ADDR];
        if (bus.CFG_WE) m_tbl[bus.CFG_ADDR] = 32'(bus.CFG_WDATA);
        @(posedge CLK);
        #1;
        m_y = ny; m_z = nz; m_ch = nc; m_rd = nr;
        check_eq("y",       32'(bus.Y),         m_y);
        check_eq("z",       32'(bus.Z),         m_z);
        check_eq("changed", 32'(bus.CHANGED),   m_ch);
        check_eq("rdata",   32'(bus.CFG_RDATA), m_rd);
    endtask

    initial begin
        drive(1'b0, 0, 0, 1'b0, 0, 0);
        model_reset();
        #2;
        check_eq("rst_y",     32'(bus.Y),         0);
        check_eq("rst_z",     32'(bus.Z),         0);
        check_eq("rst_ch",    32'(bus.CHANGED),   0);
        check_eq("rst_rdata", 32'(bus.CFG_RDATA), 0);
        #10;
        RST = 1'b0;

        // Unprogrammed table holds state; readback shows self-loops.
        for (int a = 0; a < 256; a++) begin
            drive(1'b1, a % 16, 0, 1'b0, a, 0);
            cycle();
            check_eq("t1_y",     32'(bus.Y),         0);
            check_eq("t1_rdata", 32'(bus.CFG_RDATA), (a / 16) * 16);
        end

        // Program and step
        drive(1'b0, 0, 3, 1'b1, 8'h35, 8'h7A); cycle();
        drive(1'b0, 0, 3, 1'b1, 8'h7C, 8'h2F); cycle();
        drive(1'b1, 5, 0, 1'b0, 0, 0);          cycle();
        check_eq("t2_y1", 32'(bus.Y), 7); check_eq("t2_z1", 32'(bus.Z), 'hA); check_eq("t2_c1", 32'(bus.CHANGED), 1);
        drive(1'b1, 'hC, 0, 1'b0, 0, 0);        cycle();
        check_eq("t2_y2", 32'(bus.Y), 2); check_eq("t2_z2", 32'(bus.Z), 'hF); check_eq("t2_c2", 32'(bus.CHANGED), 1);
        drive(1'b1, 0, 0, 1'b0, 0, 0);          cycle();
        check_eq("t2_y3", 32'(bus.Y), 2); check_eq("t2_z3", 32'(bus.Z), 0); check_eq("t2_c3", 32'(bus.CHANGED), 0);

        // Write/step collision uses the old entry
        drive(1'b0, 0, 3, 1'b0, 0, 0);          cycle();
        drive(1'b1, 5, 0, 1'b1, 8'h35, 8'h9B);  cycle();
        check_eq("t3_y_old", 32'(bus.Y), 7); check_eq("t3_z_old", 32'(bus.Z), 'hA);
        drive(1'b0, 0, 3, 1'b0, 0, 0);          cycle();
        drive(1'b1, 5, 0, 1'b0, 0, 0);          cycle();
        check_eq("t3_y_new", 32'(bus.Y), 9); check_eq("t3_z_new", 32'(bus.Z), 'hB);

        // Preset overrides stepping
        drive(1'b0, 5, 'hE, 1'b1, 8'hE5, 8'h11); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5, 'hE, 1'b0, 0, 0);     cycle();
            check_eq("t4_y", 32'(bus.Y), 'hE); check_eq("t4_z", 32'(bus.Z), 0); check_eq("t4_c", 32'(bus.CHANGED), 0);
        end

        // Write/read collision returns the old value
        drive(1'b0, 0, 0, 1'b1, 8'h42, 8'hC3);  cycle();
        check_eq("t5_old", 32'(bus.CFG_RDATA), 'h40);
        drive(1'b0, 0, 0, 1'b0, 8'h42, 0);      cycle();
        check_eq("t5_new", 32'(bus.CFG_RDATA), 'hC3);

        // Asynchronous reset between edges
        drive(1'b0, 0, 3, 1'b1, 8'h35, 8'h7A);  cycle();
        drive(1'b1, 5, 0, 1'b0, 0, 0);          cycle();
        check_eq("t6_pre_z", 32'(bus.Z), 'hA);
        #2;
        RST = 1'b1;
        #1;
        check_eq("t6_y", 32'(bus.Y), 0);
        check_eq("t6_z", 32'(bus.Z), 0);
        check_eq("t6_c", 32'(bus.CHANGED), 0);
        #1;
        RST = 1'b0;
        model_reset();
        drive(1'b1, 5, 0, 1'b0, 8'h35, 0);      cycle();
        check_eq("t6_tbl", 32'(bus.CFG_RDATA), 'h30);
        check_eq("t6_hold", 32'(bus.Y), 0);

        // Randomized traffic, half of the writes aimed at the entry being stepped
        for (int n = 0; n < 600; n++) begin
            int unsigned x, addr;
            bit en, we;
            x    = $urandom_range(0, 15);
            en   = ($urandom_range(0, 4) != 0);
            we   = ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 1) == 0) ? (m_y * 16 + x) : $urandom_range(0, 255);
            drive(en, x, $urandom_range(0, 15), we, addr, $urandom_range(0, 255));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/table_fsm.md
# table_fsm

Runtime-programmable, table-driven finite state machine: a next-state/output table indexed by {current state, input symbol}, advanced one transition per enabled clock. It generalises the team's fixed 16×16 ROM-table FSM with:
- parametrised state, input and output widths;
- a writable and readable configuration port;
- a registered per-transition output and a change flag;
- asynchronous reset.

It sits behind the JTAG-side control logic, so sequencing behaviour can be reprogrammed without resynthesis.

## Interface
- STATE_W, 4: state width; table has 2^STATE_W × 2^IN_W entries.
- IN_W, 4: input symbol width.
- OUT_W, 4: per-transition output width.
- RESET_STATE, 0: value of Y after reset (STATE_W bits).

- CLK  in  1  sole clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = step the FSM; 0 = load PRESET_Y.
- X  in  IN_W  input symbol for the current step.
- PRESET_Y  in  STATE_W  state loaded while ENABLE = 0.
- Y  out  STATE_W  current state (register).
- Z  out  OUT_W  output of the last transition taken (register).
- CHANGED  out  1  high for one cycle after a step that changed Y.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  STATE_W+IN_W  table index = {state, symbol}, i.e. state·2^IN_W + symbol.
- CFG_WDATA  in  STATE_W+OUT_W  entry = {next_state, out}, next_state in the MSBs.
- CFG_RDATA  out  STATE_W+OUT_W  registered read of the entry at the previous cycle's CFG_ADDR.

## Operation
- Table: 2^(STATE_W+IN_W) entries, register-based, with a combinational read for the FSM lookup.
- Reset (RST = 1, asynchronous):
  - Y = RESET_STATE; Z = 0; CHANGED = 0; CFG_RDATA = 0.
  - Every entry {s, x} = {s, 0}: self-loop, output 0. An unprogrammed FSM therefore holds its state.
- Priority at each edge, when RST = 0:
  - ENABLE = 0: Y <= PRESET_Y; Z <= 0; CHANGED <= 0.
  - ENABLE = 1: entry E = table[{Y, X}]. Then Y <= E.next_state, Z <= E.out, CHANGED <= (E.next_state != Y).
- Configuration is independent of ENABLE:
  - CFG_WE = 1 writes CFG_WDATA to table[CFG_ADDR] at the edge.
  - CFG_RDATA <= table[CFG_ADDR] every cycle, using pre-write contents.
- Write/step collision: if CFG_WE targets the entry the FSM reads in the same cycle, the step uses the old entry. The new entry applies from the next cycle.
- Write/read collision on the same address: CFG_RDATA returns the old value. The new value is visible one cycle later.
- No arithmetic beyond index concatenation. The index width is exactly STATE_W+IN_W, so there is no overflow or out-of-range address.
- Reset mid-operation: takes effect immediately, regardless of CLK. All table contents revert to self-loops and programming is lost. An in-flight write in that cycle is discarded.

## Timing
- Step latency: 1 cycle from the sampling edge. X, Y and the table are sampled at edge n; new Y, Z and CHANGED are valid after edge n.
- Preset latency: 1 cycle. Y = PRESET_Y after the edge; holding ENABLE = 0 re-loads every cycle.
- Read latency: 1 cycle from CFG_ADDR.
- Write-to-use latency: a write at edge n affects a step sampled at edge n+1 or later.
- Release of RST is synchronous in effect: the first step occurs at the first rising edge with RST = 0.
- CHANGED is a one-cycle pulse per changing step. It stays high across consecutive changing steps.

## Test plan
Defaults: STATE_W = IN_W = OUT_W = 4.
1. Reset hold: pulse RST, then ENABLE = 1 with X sweeping 0..F for 16 cycles -> Y = 0, Z = 0, CHANGED = 0 throughout. Read every CFG_ADDR -> CFG_RDATA = {addr[7:4], 0}.
2. Program and step: write 0x35 <- 0x7A and 0x7C <- 0x2F. Preset Y = 3. ENABLE = 1 with X = 5, then X = C -> after the first edge Y = 7, Z = A, CHANGED = 1; after the second edge Y = 2, Z = F, CHANGED = 1. Next step with X = 0 (unprogrammed entry 0x20) -> Y = 2, Z = 0, CHANGED = 0.
3. Collision: Y = 3, X = 5, table[0x35] = 0x7A. In the same cycle write 0x35 <- 0x9B and step -> Y = 7, Z = A. Return to Y = 3 via preset, step X = 5 -> Y = 9, Z = B.
4. Preset priority: ENABLE = 0, PRESET_Y = E, X = 5, table[0xE5] = 0x11 -> Y = E, Z = 0, CHANGED = 0 on every cycle ENABLE stays low.
5. Readback: write 0x42 <- 0xC3. Read 0x42 in the same cycle -> old 0x40. Read again next cycle -> 0xC3, one cycle after the address.
6. Async reset mid-run: after programming, assert RST between clock edges while stepping -> Y = 0 and Z = 0 before the next edge. Table returns to self-loops (check 0x35 -> 0x30).
